// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: byte-lane store/load handling over a
// req/gnt/rvalid data-memory port, stalling upstream while busy.
module mem_stage_lsu #(
    parameter int addrWidth = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [31:0]          inst_in,
    input  logic [31:0]          alu_out_in,
    input  logic [31:0]          rs2_rdata_in,
    output logic                 stall,
    output logic                 fault,
    output logic                 load_valid,
    output logic [31:0]          load_data,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [addrWidth-1:0] dm_addr,
    output logic [3:0]           dm_wstrb,
    output logic [31:0]          dm_wdata,
    input  logic                 dm_gnt,
    input  logic                 dm_rvalid,
    input  logic [31:0]          dm_rdata
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [6:0]  opcode;
    logic [2:0]  f3, f3_q;
    logic [1:0]  off, off_q;
    logic        is_ld, is_st, mem_op, legal, misal, start;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata, sh, ext;
    logic        unused;

    assign unused = ^{inst_in[31:15], inst_in[11:7], alu_out_in[31:addrWidth]};

    assign opcode = inst_in[6:0];
    assign f3     = inst_in[14:12];
    assign off    = alu_out_in[1:0];
    assign is_ld  = (opcode == OP_LOAD);
    assign is_st  = (opcode == OP_STORE);
    assign mem_op = valid_in & (is_ld | is_st);
    assign legal  = is_ld ? (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7)
                          : (!f3[2] && f3[1:0] != 2'b11);
    assign misal  = ((f3[1:0] == 2'b01) & off[0]) |
                    ((f3[1:0] == 2'b10) & (|off));
    assign fault  = mem_op & (~legal | misal);
    assign start  = mem_op & legal & ~misal;

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = rs2_rdata_in;
        unique case (1'b1)
            (f3[1:0] == 2'b00): begin
                st_wstrb = 4'b0001 << off;
                st_wdata = {4{rs2_rdata_in[7:0]}};
            end
            (f3[1:0] == 2'b01): begin
                st_wstrb = off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{rs2_rdata_in[15:0]}};
            end
            default: ;
        endcase
        if (is_ld)
            st_wstrb = 4'b0000;
    end

    // Lane selection uses the offset captured at issue, not the live address.
    always_comb begin
        sh  = dm_rdata >> {off_q, 3'b000};
        ext = dm_rdata;
        unique case (f3_q)
            3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
            3'b100:  ext = {24'd0, sh[7:0]};
            3'b101:  ext = {16'd0, sh[15:0]};
            default: ext = dm_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        dm_req     = 1'b0;
        load_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = start;
                if (start)
                    state_d = REQ;
            end
            REQ: begin
                stall  = 1'b1;
                dm_req = 1'b1;
                if (dm_gnt)
                    state_d = dm_we ? DONE : WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (dm_rvalid)
                    state_d = DONE;
            end
            DONE: begin
                load_valid = ~dm_we;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wstrb  <= 4'b0000;
            dm_wdata  <= 32'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            load_data <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                dm_we    <= is_st;
                dm_addr  <= {alu_out_in[addrWidth-1:2], 2'b00};
                dm_wstrb <= st_wstrb;
                dm_wdata <= st_wdata;
                f3_q     <= f3;
                off_q    <= off;
            end
            if (state_q == WAIT && dm_rvalid)
                load_data <= ext;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases plus randomized accesses
// checked against a byte-arithmetic reference model.
module tb_mem_stage_lsu;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] inst_in = 32'd0;
    logic [31:0] alu_out_in = 32'd0;
    logic [31:0] rs2_rdata_in = 32'd0;
    logic        stall, fault, load_valid;
    logic [31:0] load_data;
    logic        dm_req, dm_we;
    logic [14:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_gnt = 1'b0;
    logic        dm_rvalid = 1'b0;
    logic [31:0] dm_rdata = 32'd0;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_ld = 32'd0;

    mem_stage_lsu #(.addrWidth(15)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .inst_in(inst_in),
        .alu_out_in(alu_out_in), .rs2_rdata_in(rs2_rdata_in),
        .stall(stall), .fault(fault), .load_valid(load_valid),
        .load_data(load_data), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit legal_f3(input bit is_ld, input logic [2:0] f3);
        if (is_ld)
            return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        return f3 inside {3'd0, 3'd1, 3'd2};
    endfunction

    function automatic logic [31:0] ext_model(input logic [2:0] f3,
                                              input int k,
                                              input logic [31:0] w);
        longint v;
        int     s;
        s = 1 << f3[1:0];
        if (s >= 4)
            return w;
        v = longint'(w >> (8 * k)) % (longint'(1) << (8 * s));
        if (!f3[2] && v >= (longint'(1) << (8 * s - 1)))
            v = v - (longint'(1) << (8 * s));
        return 32'(v);
    endfunction

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rs2);
        logic [31:0] rnd;
        rnd          = $urandom();
        valid_in     = 1'b1;
        inst_in      = {rnd[31:15], f3, rnd[11:7], op};
        alu_out_in   = a;
        rs2_rdata_in = rs2;
    endtask

    // g: REQ cycles before the one with gnt; r: WAIT cycles before rvalid
    task automatic access(input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] rs2,
                          input int g, input int r,
                          input logic [31:0] rdata);
        bit          is_ld, is_mem, flt;
        int          s, k, m;
        logic [31:0] xstrb, xwdata, xld, rnd;
        is_ld  = (op == LD);
        is_mem = is_ld || (op == ST);
        s      = 1 << f3[1:0];
        k      = int'(a[1:0]);
        flt    = is_mem && (!legal_f3(is_ld, f3) || (k % s) != 0);
        m      = ((1 << s) - 1) << k;
        xstrb  = is_ld ? 32'd0 : 32'(m);
        for (int i = 0; i < 4; i++)
            xwdata[8*i +: 8] = rs2[8*(i % s) +: 8];
        xld = ext_model(f3, k, rdata);

        @(negedge clk);
        rnd = $urandom();
        drive(op, f3, a, rs2);
        dm_gnt    = rnd[0];
        dm_rvalid = rnd[1];
        #1;
        chk("fault", {31'd0, fault}, {31'd0, flt});
        if (!is_mem || flt) begin
            chk("nomem_stall", {31'd0, stall}, 32'd0);
            chk("nomem_req", {31'd0, dm_req}, 32'd0);
            @(negedge clk);
            dm_gnt    = 1'b0;
            dm_rvalid = 1'b0;
            #1;
            chk("nomem_req2", {31'd0, dm_req}, 32'd0);
            chk("nomem_stall2", {31'd0, stall}, 32'd0);
            return;
        end
        chk("idle_stall", {31'd0, stall}, 32'd1);
        chk("idle_req", {31'd0, dm_req}, 32'd0);

        for (int i = 0; i <= g; i++) begin
            @(negedge clk);
            rnd       = $urandom();
            dm_gnt    = (i == g);
            dm_rvalid = rnd[0];
            dm_rdata  = rnd;
            #1;
            chk("req", {31'd0, dm_req}, 32'd1);
            chk("req_stall", {31'd0, stall}, 32'd1);
            chk("we", {31'd0, dm_we}, {31'd0, !is_ld});
            chk("addr", {17'd0, dm_addr}, a & 32'h7FFC);
            chk("wstrb", {28'd0, dm_wstrb}, xstrb);
            if (!is_ld)
                chk("wdata", dm_wdata, xwdata);
        end

        if (is_ld) begin
            for (int i = 0; i <= r; i++) begin
                @(negedge clk);
                rnd       = $urandom();
                dm_gnt    = rnd[0];
                dm_rvalid = (i == r);
                dm_rdata  = (i == r) ? rdata : rnd;
                #1;
                chk("wait_req", {31'd0, dm_req}, 32'd0);
                chk("wait_stall", {31'd0, stall}, 32'd1);
                chk("wait_lv", {31'd0, load_valid}, 32'd0);
            end
            model_ld = xld;
        end

        @(negedge clk);
        rnd       = $urandom();
        dm_gnt    = rnd[0];
        dm_rvalid = rnd[1];
        dm_rdata  = rnd;
        #1;
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_req", {31'd0, dm_req}, 32'd0);
        chk("done_lv", {31'd0, load_valid}, {31'd0, is_ld});
        chk("load_data", load_data, model_ld);
    endtask

    initial begin
        #1;
        chk("rst_req", {31'd0, dm_req}, 32'd0);
        chk("rst_we", {31'd0, dm_we}, 32'd0);
        chk("rst_addr", {17'd0, dm_addr}, 32'd0);
        chk("rst_wstrb", {28'd0, dm_wstrb}, 32'd0);
        chk("rst_wdata", dm_wdata, 32'd0);
        chk("rst_lv", {31'd0, load_valid}, 32'd0);
        chk("rst_ld", load_data, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        access(ST, 3'd2, 32'h104, 32'hDEADBEEF, 0, 0, 32'd0);
        access(ST, 3'd0, 32'h203, 32'h000000A5, 0, 0, 32'd0);
        access(LD, 3'd0, 32'h102, 32'd0, 2, 2, 32'h00800000);
        chk("lb_val", load_data, 32'hFFFFFF80);
        access(LD, 3'd5, 32'h106, 32'd0, 0, 0, 32'h80011234);
        chk("lhu_val", load_data, 32'h00008001);
        access(LD, 3'd1, 32'h106, 32'd0, 1, 0, 32'h80011234);
        chk("lh_val", load_data, 32'hFFFF8001);
        access(LD, 3'd2, 32'h102, 32'd0, 0, 0, 32'd0);
        access(ALU, 3'd0, 32'h100, 32'd0, 0, 0, 32'd0);
        access(ST, 3'd3, 32'h100, 32'd0, 0, 0, 32'd0);

        @(negedge clk);
        drive(ST, 3'd2, 32'h40, 32'h12345678);
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        #1 chk("rq_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1 chk("rq_req", {31'd0, dm_req}, 32'd1);
        #2;
        rst      = 1'b0;
        valid_in = 1'b0;
        model_ld = 32'd0;
        #1;
        chk("rq_rst_req", {31'd0, dm_req}, 32'd0);
        chk("rq_rst_addr", {17'd0, dm_addr}, 32'd0);
        chk("rq_rst_wstrb", {28'd0, dm_wstrb}, 32'd0);
        chk("rq_rst_wdata", dm_wdata, 32'd0);
        chk("rq_rst_ld", load_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rq_idle", {31'd0, dm_req}, 32'd0);

        @(negedge clk);
        drive(LD, 3'd2, 32'h80, 32'd0);
        #1 chk("wt_stall0", {31'd0, stall}, 32'd1);
        @(negedge clk);
        dm_gnt = 1'b1;
        #1 chk("wt_req", {31'd0, dm_req}, 32'd1);
        @(negedge clk);
        dm_gnt = 1'b0;
        #1 chk("wt_wait", {31'd0, stall}, 32'd1);
        #2;
        rst      = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("wt_rst_req", {31'd0, dm_req}, 32'd0);
        chk("wt_rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst       = 1'b1;
        dm_rvalid = 1'b1;
        dm_rdata  = 32'hFFFFFFFF;
        #1;
        chk("stray_lv", {31'd0, load_valid}, 32'd0);
        chk("stray_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        dm_rvalid = 1'b0;
        #1;
        chk("stray_ld", load_data, 32'd0);
        chk("stray_lv2", {31'd0, load_valid}, 32'd0);
        chk("stray_req", {31'd0, dm_req}, 32'd0);
        access(LD, 3'd2, 32'h80, 32'd0, 0, 0, 32'hCAFEF00D);
        chk("lw_after_rst", load_data, 32'hCAFEF00D);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a, rs2, rd;
            logic [6:0]  op;
            logic [2:0]  f3;
            int          kind;
            kind = $urandom_range(0, 9);
            a    = $urandom();
            rs2  = $urandom();
            rd   = $urandom();
            f3   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                a[1:0] = 2'b00;
            op = (kind == 0) ? ALU : (kind < 5) ? LD : ST;
            access(op, f3, a, rs2, $urandom_range(0, 3),
                   $urandom_range(0, 3), rd);
        end

        @(negedge clk);
        valid_in = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
